mem_bus_arbiter: RTL and testbench

//   Two-master MemoryBus arbiter; replaces the static probe/CPU select mux in

---
 rtl/mem_bus_arbiter.sv | 174 +++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Two-master MemoryBus arbiter: grants whole transactions to the debug probe (A)
// or the multicycle core (B), with optional round-robin and a done watchdog.

package MemoryBus;

  typedef struct packed {
    logic        start;
    logic [31:0] wdata;
    logic [3:0]  byteEn;
  } Cmd;

  typedef struct packed {
    logic [31:0] data;
    logic        done;
  } Result;

endpackage

module mem_bus_arbiter
  import MemoryBus::*;
#(
  parameter bit          FIXED_PRIO_A   = 1'b0,
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned CNT_W          = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [29:0] a_address,
  input  logic        a_we,
  input  Cmd          a_cmd,
  output Result       a_result,
  output logic        a_err,
  input  logic [29:0] b_address,
  input  logic        b_we,
  input  Cmd          b_cmd,
  output Result       b_result,
  output logic        b_err,
  output logic [29:0] m_address,
  output logic        m_we,
  output Cmd          m_cmd,
  input  Result       m_result,
  output logic        grant_a,
  output logic        grant_b
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RELEASE
  } state_e;

  typedef enum logic {
    OWN_A,
    OWN_B
  } owner_e;

  localparam bit               TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  owner_e            last_q, last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [29:0] selAddr;
  logic        selWe;
  Cmd          selCmd;
  Result       fwdRes;
  logic        fwdErr;
  logic        busy;

  // State, owner, last-owner and watchdog registers; last owner starts as B so A wins the first tie
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= OWN_A;
      last_q  <= OWN_B;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, bus drive and result routing; done or abort only ever reaches the owner
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    selAddr   = (owner_q == OWN_B) ? b_address : a_address;
    selWe     = (owner_q == OWN_B) ? b_we : a_we;
    selCmd    = (owner_q == OWN_B) ? b_cmd : a_cmd;
    fwdRes    = '0;
    fwdErr    = 1'b0;
    busy      = 1'b0;
    m_address = '0;
    m_we      = 1'b0;
    m_cmd     = '0;

    case (state_q)
      IDLE: begin
        if (a_cmd.start || b_cmd.start) begin
          state_d = ISSUE;
          if (a_cmd.start && b_cmd.start) begin
            if (FIXED_PRIO_A) begin
              owner_d = OWN_A;
            end else begin
              owner_d = (last_q == OWN_A) ? OWN_B : OWN_A;
            end
          end else if (a_cmd.start) begin
            owner_d = OWN_A;
          end else begin
            owner_d = OWN_B;
          end
        end
      end

      ISSUE: begin
        busy        = 1'b1;
        m_address   = selAddr;
        m_we        = selWe;
        m_cmd       = selCmd;
        m_cmd.start = 1'b1;
        cnt_d       = '0;
        if (m_result.done) begin
          fwdRes  = m_result;
          last_d  = owner_q;
          state_d = RELEASE;
        end else begin
          state_d = WAIT;
        end
      end

      WAIT: begin
        busy        = 1'b1;
        m_address   = selAddr;
        m_we        = selWe;
        m_cmd       = selCmd;
        m_cmd.start = 1'b0;
        cnt_d       = cnt_q + CNT_W'(1);
        if (m_result.done) begin
          fwdRes  = m_result;
          last_d  = owner_q;
          state_d = RELEASE;
        end else if (TIMEOUT_EN && (cnt_q == LAST_CNT)) begin
          fwdRes.data = '0;
          fwdRes.done = 1'b1;
          fwdErr      = 1'b1;
          state_d     = RELEASE;
        end
      end

      RELEASE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    grant_a  = busy && (owner_q == OWN_A);
    grant_b  = busy && (owner_q == OWN_B);
    a_result = (owner_q == OWN_A) ? fwdRes : '0;
    b_result = (owner_q == OWN_B) ? fwdRes : '0;
    a_err    = fwdErr && (owner_q == OWN_A);
    b_err    = fwdErr && (owner_q == OWN_B);
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: one round-robin and one fixed-priority
// instance share the master and slave stimulus; each check names its instance.

module tb_mem_bus_arbiter;
  import MemoryBus::*;

  logic        clk;
  logic        rst;
  logic [29:0] aAddress;
  logic        aWe;
  Cmd          aCmd;
  logic [29:0] bAddress;
  logic        bWe;
  Cmd          bCmd;
  Result       mResult;

  Result       rrAResult, rrBResult, fpAResult, fpBResult;
  logic        rrAErr, rrBErr, fpAErr, fpBErr;
  logic [29:0] rrMAddress, fpMAddress;
  logic        rrMWe, fpMWe;
  Cmd          rrMCmd, fpMCmd;
  logic        rrGrantA, rrGrantB, fpGrantA, fpGrantB;

  int compareCount  = 0;
  int mismatchCount = 0;

  mem_bus_arbiter #(
    .FIXED_PRIO_A  (1'b0),
    .TIMEOUT_CYCLES(8),
    .CNT_W         (4)
  ) dutRr (
    .clk      (clk),
    .rst      (rst),
    .a_address(aAddress),
    .a_we     (aWe),
    .a_cmd    (aCmd),
    .a_result (rrAResult),
    .a_err    (rrAErr),
    .b_address(bAddress),
    .b_we     (bWe),
    .b_cmd    (bCmd),
    .b_result (rrBResult),
    .b_err    (rrBErr),
    .m_address(rrMAddress),
    .m_we     (rrMWe),
    .m_cmd    (rrMCmd),
    .m_result (mResult),
    .grant_a  (rrGrantA),
    .grant_b  (rrGrantB)
  );

  mem_bus_arbiter #(
    .FIXED_PRIO_A  (1'b1),
    .TIMEOUT_CYCLES(8),
    .CNT_W         (4)
  ) dutFp (
    .clk      (clk),
    .rst      (rst),
    .a_address(aAddress),
    .a_we     (aWe),
    .a_cmd    (aCmd),
    .a_result (fpAResult),
    .a_err    (fpAErr),
    .b_address(bAddress),
    .b_we     (bWe),
    .b_cmd    (bCmd),
    .b_result (fpBResult),
    .b_err    (fpBErr),
    .m_address(fpMAddress),
    .m_we     (fpMWe),
    .m_cmd    (fpMCmd),
    .m_result (mResult),
    .grant_a  (fpGrantA),
    .grant_b  (fpGrantB)
  );

  // Free-running 10-time-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case a wait ever runs away
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got still running want finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%0h want 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic startA, input logic [29:0] addrA, input logic weA,
                               input logic startB, input logic [29:0] addrB, input logic weB);
    aCmd.start = startA;
    aAddress   = addrA;
    aWe        = weA;
    bCmd.start = startB;
    bAddress   = addrB;
    bWe        = weB;
  endtask

  task automatic applyReset();
    rst      = 1'b1;
    aCmd     = '0;
    bCmd     = '0;
    aAddress = '0;
    bAddress = '0;
    aWe      = 1'b0;
    bWe      = 1'b0;
    mResult  = '0;
    nextCycle();
    nextCycle();
    rst = 1'b0;
  endtask

  // Both masters want 3 transactions each, drop start for the cycle after done,
  // then re-request; slave answers done in the first WAIT cycle
  task automatic runContention(input bit useFixed, output logic [5:0] order, output int grants);
    int  aLeft = 3;
    int  bLeft = 3;
    bit  aDrop = 1'b0;
    bit  bDrop = 1'b0;
    bit  prevIssue = 1'b0;
    bit  issue;
    bit  ga;
    bit  aDone;
    bit  bDone;
    order  = '0;
    grants = 0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      nextCycle();
      mResult.done = prevIssue;
      mResult.data = 32'hA5A5_0000 + 32'(cyc);
      aCmd.start   = (aLeft > 0) && !aDrop;
      bCmd.start   = (bLeft > 0) && !bDrop;
      #2;
      issue = useFixed ? fpMCmd.start : rrMCmd.start;
      ga    = useFixed ? fpGrantA : rrGrantA;
      aDone = useFixed ? fpAResult.done : rrAResult.done;
      bDone = useFixed ? fpBResult.done : rrBResult.done;
      if (issue && grants < 6) begin
        order[grants] = !ga;
        grants++;
      end
      if (aDone) aLeft--;
      if (bDone) bLeft--;
      aDrop     = aDone;
      bDrop     = bDone;
      prevIssue = issue;
      if (grants == 6) break;
    end
    aCmd.start = 1'b0;
    bCmd.start = 1'b0;
    mResult    = '0;
  endtask

  initial begin
    int          doneAt;
    logic        errSeen;
    logic        bErrSeen;
    logic [31:0] dataSeen;
    logic [5:0]  order;
    int          grants;

    $display("[TB] start");
    aCmd = '0;
    bCmd = '0;

    // Reset state
    applyReset();
    #2;
    checkOutput("reset_grants", 64'({rrGrantA, rrGrantB, fpGrantA, fpGrantB}), 64'd0);
    checkOutput("reset_mcmd", 64'(rrMCmd), 64'd0);
    checkOutput("reset_maddr_we", 64'({rrMAddress, rrMWe}), 64'd0);
    checkOutput("reset_results", 64'({rrAResult, rrBResult, rrAErr, rrBErr}), 64'd0);

    // A-only read, slave done 3 cycles after start
    applyStimulus(1'b1, 30'h0000_1234, 1'b0, 1'b0, 30'h0, 1'b0);
    #2;
    checkOutput("t1_idle_nogrant", 64'(rrGrantA), 64'd0);
    nextCycle();
    #2;
    checkOutput("t1_issue_start", 64'(rrMCmd.start), 64'd1);
    checkOutput("t1_issue_addr", 64'(rrMAddress), 64'h1234);
    checkOutput("t1_issue_grant", 64'({rrGrantA, rrGrantB}), 64'b10);
    nextCycle();
    #2;
    checkOutput("t1_wait_start", 64'(rrMCmd.start), 64'd0);
    checkOutput("t1_wait_nodone", 64'(rrAResult.done), 64'd0);
    nextCycle();
    nextCycle();
    mResult = '{data: 32'hDEAD_BEEF, done: 1'b1};
    #2;
    checkOutput("t1_a_done", 64'(rrAResult.done), 64'd1);
    checkOutput("t1_a_data", 64'(rrAResult.data), 64'hDEAD_BEEF);
    checkOutput("t1_b_quiet", 64'({rrBResult, rrAErr, rrBErr}), 64'd0);
    nextCycle();
    mResult    = '0;
    aCmd.start = 1'b0;
    #2;
    checkOutput("t1_release_bus", 64'({rrGrantA, rrMCmd.start, rrMAddress}), 64'd0);
    nextCycle();

    // Master holds start one cycle after done: no regrant
    aCmd.wdata = 32'hCAFE_0001;
    applyStimulus(1'b1, 30'h0000_2000, 1'b1, 1'b0, 30'h0, 1'b0);
    nextCycle();
    #2;
    checkOutput("t6_issue_we", 64'(rrMWe), 64'd1);
    checkOutput("t6_issue_wdata", 64'(rrMCmd.wdata), 64'hCAFE_0001);
    nextCycle();
    mResult = '{data: 32'h0, done: 1'b1};
    #2;
    checkOutput("t6_done", 64'(rrAResult.done), 64'd1);
    nextCycle();
    mResult = '0;
    #2;
    checkOutput("t6_release_grant", 64'(rrGrantA), 64'd0);
    nextCycle();
    aCmd = '0;
    #2;
    checkOutput("t6_idle_noregrant", 64'({rrGrantA, rrMCmd.start}), 64'd0);
    nextCycle();
    #2;
    checkOutput("t6_still_idle", 64'({rrGrantA, rrMCmd.start}), 64'd0);

    // Zero-wait slave, B queued behind A
    applyStimulus(1'b1, 30'h0000_3000, 1'b0, 1'b0, 30'h0, 1'b0);
    nextCycle();
    mResult    = '{data: 32'h1234_5678, done: 1'b1};
    bCmd.start = 1'b1;
    bAddress   = 30'h0000_3333;
    #2;
    checkOutput("t3_a_zero_wait_done", 64'({rrAResult.done, rrGrantA}), 64'b11);
    checkOutput("t3_a_zero_wait_data", 64'(rrAResult.data), 64'h1234_5678);
    nextCycle();
    mResult    = '0;
    aCmd.start = 1'b0;
    #2;
    checkOutput("t3_release_no_b", 64'({rrGrantB, rrMCmd.start}), 64'd0);
    nextCycle();
    #2;
    checkOutput("t3_idle_no_b", 64'(rrGrantB), 64'd0);
    nextCycle();
    mResult = '{data: 32'h0BAD_F00D, done: 1'b1};
    #2;
    checkOutput("t3_b_issue", 64'({rrGrantB, rrMCmd.start, rrMAddress}), 64'({2'b11, 30'h0000_3333}));
    checkOutput("t3_b_done", 64'({rrBResult.done, rrAResult.done}), 64'b10);
    nextCycle();
    mResult    = '0;
    bCmd.start = 1'b0;
    nextCycle();

    // Watchdog: slave silent, abort 8 cycles after ISSUE
    applyReset();
    applyStimulus(1'b1, 30'h0000_4000, 1'b0, 1'b0, 30'h0, 1'b0);
    mResult = '{data: 32'hFFFF_FFFF, done: 1'b0};
    nextCycle();
    doneAt   = -1;
    errSeen  = 1'b0;
    bErrSeen = 1'b0;
    dataSeen = '0;
    for (int k = 1; k <= 20; k++) begin
      nextCycle();
      #2;
      if (rrAResult.done) begin
        doneAt   = k;
        errSeen  = rrAErr;
        bErrSeen = rrBErr;
        dataSeen = rrAResult.data;
        break;
      end
    end
    checkOutput("t4_timeout_cycle", 64'(doneAt), 64'd8);
    checkOutput("t4_timeout_err", 64'({errSeen, bErrSeen}), 64'b10);
    checkOutput("t4_timeout_data", 64'(dataSeen), 64'd0);
    nextCycle();
    aCmd.start = 1'b0;
    mResult    = '0;
    nextCycle();
    applyStimulus(1'b0, 30'h0, 1'b0, 1'b1, 30'h0000_5000, 1'b0);
    nextCycle();
    #2;
    checkOutput("t4_next_grant", 64'({rrGrantB, rrMCmd.start}), 64'b11);
    nextCycle();
    mResult = '{data: 32'h600D_600D, done: 1'b1};
    #2;
    checkOutput("t4_next_done", 64'({rrBResult.done, rrBErr}), 64'b10);
    checkOutput("t4_next_data", 64'(rrBResult.data), 64'h600D_600D);
    nextCycle();
    mResult    = '0;
    bCmd.start = 1'b0;
    nextCycle();

    // Reset pulsed mid-WAIT, then a late slave done
    applyReset();
    applyStimulus(1'b1, 30'h0000_6000, 1'b1, 1'b0, 30'h0, 1'b0);
    nextCycle();
    nextCycle();
    rst = 1'b1;
    nextCycle();
    rst        = 1'b0;
    aCmd.start = 1'b0;
    mResult    = '{data: 32'h7777_7777, done: 1'b1};
    #2;
    checkOutput("t5_no_done", 64'({rrAResult, rrBResult, rrAErr, rrBErr}), 64'd0);
    checkOutput("t5_idle_bus", 64'({rrGrantA, rrGrantB, rrMWe, rrMAddress}), 64'd0);
    checkOutput("t5_idle_cmd", 64'(rrMCmd), 64'd0);
    nextCycle();
    mResult = '0;
    #2;
    checkOutput("t5_stays_idle", 64'({rrGrantA, rrMCmd.start}), 64'd0);

    // Contention: round-robin alternates, fixed priority lets A run first
    applyReset();
    runContention(1'b0, order, grants);
    checkOutput("t2_rr_grants", 64'(grants), 64'd6);
    checkOutput("t2_rr_order", 64'(order), 64'b101010);
    applyReset();
    runContention(1'b1, order, grants);
    checkOutput("t2_fp_grants", 64'(grants), 64'd6);
    checkOutput("t2_fp_order", 64'(order), 64'b111000);
    applyReset();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
